// File: rtl/lock_sequence_controller_pkg.sv
// Shared definitions for the lock sequence controller.
// Contents: controller state enum, width helper functions and the default
// duration/attempt constants.
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ENTRY    = 3'd1,
    ERROR    = 3'd2,
    LOCKOUT  = 3'd3,
    UNLOCKED = 3'd4,
    PROGRAM  = 3'd5
  } state_t;

  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_ERROR_CYCLES   = 25_000_000;
  localparam int DEF_LOCKOUT_CYCLES = 250_000_000;
  localparam int DEF_ENTRY_TIMEOUT  = 500_000_000;

  // Bits needed to encode a button index.
  function automatic int digit_w(input int buttons);
    return (buttons > 1) ? $clog2(buttons) : 1;
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_sequence_controller_if.sv
// Signal bundle between the button/setCode source and the lock controller.
// Inputs to the controller: buttonEdge (one-cycle pulses), setCode (level).
// Outputs from the controller: status flags, digitCount and debug state.
//
// Handshake: buttonEdge is the only transfer and is valid-only. A value with
// exactly one bit set is a digit event and is consumed in the cycle it is
// presented; there is no ready, the controller always accepts an event or
// deliberately ignores it (multi-bit values, ERROR/LOCKOUT states).
interface lock_sequence_controller_if #(
  parameter int BUTTONS      = 4,
  parameter int CODE_LENGTH  = 4,
  parameter int MAX_ATTEMPTS = 3
);
  import lock_pkg::*;

  localparam int CNT_W  = cnt_w(CODE_LENGTH);
  localparam int FAIL_W = cnt_w(MAX_ATTEMPTS);

  logic [BUTTONS-1:0] buttonEdge;
  logic               setCode;
  logic               locked;
  logic               unlocked;
  logic               programming;
  logic               error;
  logic               lockout;
  logic [CNT_W-1:0]   digitCount;
  state_t             dbg_state;
  logic [FAIL_W-1:0]  dbg_fail_count;

  modport master (
    output buttonEdge, setCode,
    input  locked, unlocked, programming, error, lockout, digitCount,
           dbg_state, dbg_fail_count
  );

  modport slave (
    input  buttonEdge, setCode,
    output locked, unlocked, programming, error, lockout, digitCount,
           dbg_state, dbg_fail_count
  );

endinterface

// File: rtl/lock_sequence_controller_onehot_to_index.sv
// Combinational one-hot decoder.
// Ports: onehot (N bits in), index (W bits out, position of a set bit),
// valid (high only when exactly one bit of onehot is set).
module onehot_to_index #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] index,
  output logic         valid
);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) index = W'(i);
    end
    valid = $onehot(onehot);
  end

endmodule

// File: rtl/lock_sequence_controller.sv
// Digit-sequence controller for the digital lock.
// Ports: clock, reset (synchronous, active low), bus (slave side of
// lock_sequence_controller_if: buttonEdge/setCode in, status flags,
// digitCount and debug state/fail count out).
// Collects button presses as digits, checks them against the stored code,
// limits retries with ERROR/LOCKOUT holds, abandons idle entries and lets the
// code be re-programmed while unlocked.
module lock_sequence_controller
  import lock_pkg::*;
#(
  parameter int BUTTONS      = 4,
  parameter int CODE_LENGTH  = 4,
  parameter logic [CODE_LENGTH*digit_w(BUTTONS)-1:0] DEFAULT_CODE = 8'hE4,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int ERROR_CYCLES   = DEF_ERROR_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT
) (
  input logic                       clock,
  input logic                       reset,
  lock_sequence_controller_if.slave bus
);

  localparam int DIGIT_W = digit_w(BUTTONS);
  localparam int CODE_W  = CODE_LENGTH * DIGIT_W;
  localparam int CNT_W   = cnt_w(CODE_LENGTH);
  localparam int FAIL_W  = cnt_w(MAX_ATTEMPTS);
  localparam int TMR_W   = cnt_w(max3(ERROR_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT));

  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(CODE_LENGTH);
  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_ATTEMPTS);
  localparam logic [TMR_W-1:0]  TMR_ERROR   = TMR_W'(ERROR_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ENTRY   = TMR_W'(ENTRY_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                mismatch_q, mismatch_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;

  logic [DIGIT_W-1:0]  press_idx;
  logic                press_vld;
  logic [DIGIT_W-1:0]  stored_digit;
  logic [CNT_W-1:0]    cnt_inc;
  logic [FAIL_W-1:0]   fail_inc;
  logic                mis_new;

  onehot_to_index #(
    .N (BUTTONS),
    .W (DIGIT_W)
  ) u_press_dec (
    .onehot (bus.buttonEdge),
    .index  (press_idx),
    .valid  (press_vld)
  );

  assign stored_digit = code_q[int'(digit_cnt_q)*DIGIT_W +: DIGIT_W];
  assign cnt_inc      = digit_cnt_q + 1'b1;
  assign fail_inc     = fail_q + 1'b1;
  // The first digit arrives in LOCKED, so the sticky flag starts fresh there.
  assign mis_new      = ((state_q == ENTRY) && mismatch_q) || (press_idx != stored_digit);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= LOCKED;
      digit_cnt_q <= '0;
      fail_q      <= '0;
      mismatch_q  <= 1'b0;
      timer_q     <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      fail_q      <= fail_d;
      mismatch_q  <= mismatch_d;
      timer_q     <= timer_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    fail_d      = fail_q;
    mismatch_d  = mismatch_q;
    timer_d     = timer_q;
    code_d      = code_q;
    shadow_d    = shadow_q;

    unique case (state_q)
      LOCKED, ENTRY: begin
        if (press_vld) begin
          if (cnt_inc == LAST_CNT) begin
            // Last digit: evaluate including this digit's compare.
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            if (!mis_new) begin
              state_d = UNLOCKED;
              fail_d  = '0;
            end else if (fail_inc == FAIL_MAX) begin
              state_d = LOCKOUT;
              fail_d  = fail_inc;
              timer_d = TMR_LOCKOUT;
            end else begin
              state_d = ERROR;
              fail_d  = fail_inc;
              timer_d = TMR_ERROR;
            end
          end else begin
            state_d     = ENTRY;
            digit_cnt_d = cnt_inc;
            mismatch_d  = mis_new;
            timer_d     = TMR_ENTRY;
          end
        end else if (state_q == ENTRY) begin
          if (timer_q == '0) begin
            state_d     = LOCKED;
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      ERROR: begin
        if (timer_q == '0) state_d = LOCKED;
        else               timer_d = timer_q - 1'b1;
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      UNLOCKED: begin
        // setCode wins over a simultaneous press; that press is dropped.
        if (bus.setCode) begin
          state_d     = PROGRAM;
          digit_cnt_d = '0;
          timer_d     = TMR_ENTRY;
        end else if (press_vld) begin
          state_d = LOCKED;
        end
      end
      PROGRAM: begin
        if (!bus.setCode) begin
          state_d     = UNLOCKED;
          digit_cnt_d = '0;
        end else if (press_vld) begin
          shadow_d[int'(digit_cnt_q)*DIGIT_W +: DIGIT_W] = press_idx;
          if (cnt_inc == LAST_CNT) begin
            code_d      = shadow_d;
            state_d     = LOCKED;
            digit_cnt_d = '0;
          end else begin
            digit_cnt_d = cnt_inc;
            timer_d     = TMR_ENTRY;
          end
        end else if (timer_q == '0) begin
          state_d     = UNLOCKED;
          digit_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d     = LOCKED;
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.locked         = (state_q == LOCKED) || (state_q == ENTRY) ||
                         (state_q == ERROR)  || (state_q == LOCKOUT);
    bus.unlocked       = (state_q == UNLOCKED);
    bus.programming    = (state_q == PROGRAM);
    bus.error          = (state_q == ERROR);
    bus.lockout        = (state_q == LOCKOUT);
    bus.digitCount     = digit_cnt_q;
    bus.dbg_state      = state_q;
    bus.dbg_fail_count = fail_q;
  end

endmodule

// File: doc/lock_sequence_controller.md
Name: lock_sequence_controller

Overview:
Sequencing controller for the digital lock. It consumes the one-cycle rising-edge pulses produced by the n-bit button monitor and collects them as code digits. It compares the entered sequence against a stored code and drives the lock status. It also handles wrong-code retry limiting, lockout, entry timeout and re-programming of the code while unlocked.

Parameters:
- BUTTONS, 4, number of buttons; the digit value is the button index, DIGIT_W = clog2(BUTTONS).
- CODE_LENGTH, 4, digits per code.
- DEFAULT_CODE, 8'hE4, reset code, CODE_LENGTH*DIGIT_W bits; digit k lives at [k*DIGIT_W +: DIGIT_W] and digit 0 is entered first. The default is digits 0,1,2,3.
- MAX_ATTEMPTS, 3, consecutive failed entries before lockout.
- ERROR_CYCLES, 25_000_000, duration of the ERROR state.
- LOCKOUT_CYCLES, 250_000_000, duration of the LOCKOUT state.
- ENTRY_TIMEOUT, 500_000_000, idle cycles in ENTRY before the entry is abandoned.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- buttonEdge  in  BUTTONS  one-cycle rising-edge pulses, one bit per button.
- setCode  in  1  level; requests programming of a new code while unlocked.
- locked  out  1  high in LOCKED, ENTRY, ERROR and LOCKOUT.
- unlocked  out  1  high in UNLOCKED.
- programming  out  1  high in PROGRAM.
- error  out  1  high in ERROR.
- lockout  out  1  high in LOCKOUT.
- digitCount  out  clog2(CODE_LENGTH+1)  digits captured in the current ENTRY or PROGRAM.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=LOCKED, locked=1, all other flags 0, digitCount=0.
  - failCount=0, mismatch=0, timers=0, stored code=DEFAULT_CODE.
  - Reset mid-operation also discards any programmed code and restores DEFAULT_CODE.
- Press event: exactly one bit of buttonEdge is high.
  - All-zero is no event.
  - Multiple bits high is invalid: ignored entirely, with no digit, no timer reset and no state change.
- All outputs are registered and decoded from the state register. An event at edge n is visible at edge n+1.
- LOCKED:
  - A press moves to ENTRY.
  - That press is digit 0: it is compared with stored digit 0, mismatch is set if unequal, and digitCount becomes 1.
- ENTRY:
  - Each press compares against stored digit[digitCount]. mismatch is sticky-ORed and digitCount is incremented.
  - On the press that makes digitCount==CODE_LENGTH, evaluation happens in the same cycle, including that last digit's compare:
    - match: go to UNLOCKED and clear failCount.
    - mismatch: failCount+1. Go to LOCKOUT if the new failCount==MAX_ATTEMPTS, otherwise go to ERROR.
  - The idle timer resets on every valid press. When it reaches ENTRY_TIMEOUT-1 with no press, go to LOCKED with digitCount=0. A timeout does not change failCount.
- ERROR: held for exactly ERROR_CYCLES cycles, then LOCKED. Presses are ignored.
- LOCKOUT: held for exactly LOCKOUT_CYCLES cycles, then LOCKED with failCount=0. Presses and setCode are ignored.
- UNLOCKED:
  - setCode==1 goes to PROGRAM with digitCount=0. setCode has priority over a simultaneous press, and that press is discarded.
  - Otherwise any press goes to LOCKED (relock).
- PROGRAM:
  - Each press writes its digit into a shadow register at digitCount.
  - The CODE_LENGTH-th press commits the shadow to the stored code in the same cycle and goes to LOCKED.
  - setCode falling before completion aborts: stored code unchanged, go to UNLOCKED.
  - The entry timeout also applies and returns to UNLOCKED.
- digitCount returns to 0 on every exit from ENTRY or PROGRAM.
- Timers are single shared down-counters sized for the largest duration constant. They load on state entry and never wrap.

Decomposition:
- Shared package lock_pkg:
  - state enum: LOCKED, ENTRY, ERROR, LOCKOUT, UNLOCKED, PROGRAM (3 bits).
  - DIGIT_W and counter-width helper functions.
  - Default duration constants.
- Sub-module onehot_to_index: converts buttonEdge to an index plus valid, where valid means exactly one bit is set. It is purely combinational and reused by the lock datapath.

Test Plan (bench parameters: ERROR_CYCLES=4, LOCKOUT_CYCLES=10, ENTRY_TIMEOUT=20, MAX_ATTEMPTS=3):
- Correct entry: pulses for buttons 0,1,2,3 with gaps -> unlocked=1 one cycle after the 4th pulse, locked=0, digitCount=0.
- Wrong entry: buttons 0,1,2,2 -> error=1 for exactly 4 cycles, then locked=1. A press during ERROR has no effect.
- Lockout: three wrong entries -> after the 3rd, lockout=1 for exactly 10 cycles. A correct code entered during lockout is ignored. Afterwards failCount=0 and a correct code unlocks.
- Programming: unlock, raise setCode, press 3,3,1,0 -> programming=1, then locked=1. Code 0,1,2,3 now fails; code 3,3,1,0 unlocks. Dropping setCode after 2 digits aborts and keeps the old code.
- Timeout and invalid input: press button 0, then idle 20 cycles -> return to LOCKED with failCount unchanged. buttonEdge=4'b0011 produces no digit and no timer reset.
- Reset mid-entry after 2 digits, and after reprogramming -> locked=1, digitCount=0, DEFAULT_CODE restored.
